// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the buffer memory responder.
// - mem_resp_state_e : INIT (array being zero-filled) / READY (serving accesses)
// - addr_width()     : address width derived from the word count
package mem_resp_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_resp_state_e;

  // A single-word array still needs one address bit so port widths stay legal.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Behavioural single-port RAM with a registered read port.
// Ports:
//   clk_i    clock
//   ce_i     access enable (active high)
//   we_i     write (1) / read (0) when ce_i=1
//   addr_i   word address, must be < DEPTH when ce_i=1
//   wdata_i  write data
//   rdata_o  read data, valid the cycle after a read; unchanged by writes
module sram_1rw
  import mem_resp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_array [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // No reset on the array or the read register so the tools can map this
  // onto a block RAM; the responder never exposes rdata_reg before a read.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      if (we_i) begin
        mem_array[addr_i] <= wdata_i;
      end else begin
        rdata_reg <= mem_array[addr_i];
      end
    end
  end

  assign rdata_o = rdata_reg;

endmodule

// File: rtl/buf_mem_responder.sv
// Memory-side responder for one matrix-mult buffer (IB, WB, PS or OB).
// Serves the core port (active-low cenb/wenb) and a host port for
// preload/readback, sharing one single-port array. The core always wins;
// the host is granted only on cycles where the core is idle and the array
// has finished its zero-fill.
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   clear_i            restart zero-fill of the whole array
//   cenb_i, wenb_i     core chip enable / write enable (active low)
//   addr_i, data_i     core address / write data
//   data_o             core read data (1-cycle latency, held between reads)
//   host_req_i         host request, held until host_gnt_o
//   host_we_i          host write (1) / read (0)
//   host_addr_i        host address
//   host_wdata_i       host write data
//   host_gnt_o         host access accepted this cycle (combinational)
//   host_rvalid_o      host read data valid (1-cycle pulse)
//   host_rdata_o       host read data, held until the next host read
//   busy_o             zero-fill in progress
//   err_o              sticky: core touched the array while busy
module buf_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic              cenb_i,
  input  logic              wenb_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_resp_state_e   state_reg, state_next;
  logic [ADDR_W-1:0] fill_ptr_reg, fill_ptr_next;
  logic              err_reg, err_next;

  // Read-return tags: which port the array output belongs to next cycle,
  // and whether that return must be forced to zero instead.
  logic              core_rd_reg, core_rd_zero_reg;
  logic              host_rd_reg, host_rd_zero_reg;
  logic [DATA_W-1:0] core_hold_reg, host_hold_reg;

  logic              core_active, core_rd, core_wr;
  logic              core_in_range, host_in_range;
  logic              host_gnt, host_rd;
  logic              in_init;

  logic              ram_ce, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] core_rdata, host_rdata;

  // ---------------------------------------------------------------------
  // Address range: only a non-power-of-two DEPTH can see addresses past
  // the end of the array.
  // ---------------------------------------------------------------------
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign core_in_range = 1'b1;
      assign host_in_range = 1'b1;
    end else begin : g_partial_range
      assign core_in_range = (int'(addr_i) < DEPTH);
      assign host_in_range = (int'(host_addr_i) < DEPTH);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Request decode and arbitration
  // ---------------------------------------------------------------------
  assign in_init     = (state_reg == INIT);
  assign core_active = ~cenb_i;
  assign core_rd     = core_active & wenb_i;
  assign core_wr     = core_active & ~wenb_i;
  assign host_gnt    = host_req_i & cenb_i & (state_reg == READY);
  assign host_rd     = host_gnt & ~host_we_i;

  // Array port mux: the zero-fill owns the array during INIT, otherwise
  // the core, otherwise a granted host. Out-of-range accesses never reach
  // the array, which both drops writes and keeps reads from indexing past
  // the end.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = fill_ptr_reg;
    ram_wdata = '0;
    if (in_init) begin
      ram_ce    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = fill_ptr_reg;
      ram_wdata = '0;
    end else if (core_active) begin
      ram_ce    = core_in_range;
      ram_we    = core_wr;
      ram_addr  = addr_i;
      ram_wdata = data_i;
    end else if (host_gnt) begin
      ram_ce    = host_in_range;
      ram_we    = host_we_i;
      ram_addr  = host_addr_i;
      ram_wdata = host_wdata_i;
    end
  end

  sram_1rw #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk_i   (clk_i),
    .ce_i    (ram_ce),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------
  // FSM: zero-fill sequencing and error flag
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    fill_ptr_next = fill_ptr_reg;
    err_next      = err_reg;
    case (state_reg)
      INIT: begin
        err_next = err_reg | core_active;
        if (clear_i) begin
          fill_ptr_next = '0;
        end else if (fill_ptr_reg == LAST_ADDR) begin
          state_next    = READY;
          fill_ptr_next = '0;
        end else begin
          fill_ptr_next = fill_ptr_reg + 1'b1;
        end
      end
      READY: begin
        if (clear_i) begin
          state_next    = INIT;
          fill_ptr_next = '0;
        end
      end
      default: begin
        state_next    = INIT;
        fill_ptr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= INIT;
      fill_ptr_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_ptr_reg <= fill_ptr_next;
      err_reg      <= err_next;
    end
  end

  // ---------------------------------------------------------------------
  // Read return: the array output is routed to whichever port issued the
  // read last cycle; each port keeps its own copy so data stays put while
  // the other port (or nobody) uses the array.
  // ---------------------------------------------------------------------
  assign core_rdata = core_rd_zero_reg ? '0 : ram_rdata;
  assign host_rdata = host_rd_zero_reg ? '0 : ram_rdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      core_rd_reg      <= 1'b0;
      core_rd_zero_reg <= 1'b0;
      host_rd_reg      <= 1'b0;
      host_rd_zero_reg <= 1'b0;
      core_hold_reg    <= '0;
      host_hold_reg    <= '0;
    end else begin
      core_rd_reg      <= core_rd;
      core_rd_zero_reg <= in_init | ~core_in_range;
      host_rd_reg      <= host_rd;
      host_rd_zero_reg <= ~host_in_range;
      if (core_rd_reg) begin
        core_hold_reg <= core_rdata;
      end
      if (host_rd_reg) begin
        host_hold_reg <= host_rdata;
      end
    end
  end

  assign data_o        = core_rd_reg ? core_rdata : core_hold_reg;
  assign host_rdata_o  = host_rd_reg ? host_rdata : host_hold_reg;
  assign host_rvalid_o = host_rd_reg;
  assign host_gnt_o    = host_gnt;
  assign busy_o        = in_init;
  assign err_o         = err_reg;

endmodule

// File: tb/tb_buf_mem_responder.sv
// Directed and randomized bench for buf_mem_responder (DATA_W=32, DEPTH=256).
// A plain array holds the expected contents; expected outputs are derived
// from the port rules (latency, priority, hold behaviour) directly.
module tb_buf_mem_responder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              clear = 1'b0;
  logic              cenb = 1'b1;
  logic              wenb = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data = '0;
  logic [DATA_W-1:0] data_out;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_data_o;
  logic [DATA_W-1:0] exp_rdata;
  logic              exp_rvalid;

  always #5 clk = ~clk;

  buf_mem_responder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .clear_i       (clear),
    .cenb_i        (cenb),
    .wenb_i        (wenb),
    .addr_i        (addr),
    .data_i        (data),
    .data_o        (data_out),
    .host_req_i    (host_req),
    .host_we_i     (host_we),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_gnt_o    (host_gnt),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .busy_o        (busy),
    .err_o         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 ns
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host access, holding the request until granted (bounded wait).
  task automatic host_op(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd);
    int waited;
    waited     = 0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = wd;
    #1;
    while (host_gnt !== 1'b1 && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    check({tag, "_gnt"}, 32'(host_gnt), 32'd1);
    tick();
    host_req = 1'b0;
    if (we) begin
      ref_mem[a] = wd;
      check({tag, "_rvalid"}, 32'(host_rvalid), 32'd0);
    end else begin
      check({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
      check({tag, "_rdata"}, host_rdata, exp_rd);
    end
    $display("host %s %s addr=%0d wdata=0x%08h rdata=0x%08h", tag, we ? "WR" : "RD", a, wd, host_rdata);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // ---------------- Reset state ----------------
    #1 rstn = 1'b0;
    host_req = 1'b1;
    host_we  = 1'b0;
    host_addr = 8'd0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_data_o", data_out, 32'd0);
    check("rst_gnt", 32'(host_gnt), 32'd0);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    $display("reset released");

    // ---------------- Initial zero-fill: busy for exactly DEPTH cycles ----
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      check("fill1_busy", 32'(busy), (i < DEPTH) ? 32'd1 : 32'd0);
      if (i < DEPTH) check("fill1_gnt", 32'(host_gnt), 32'd0);
    end
    check("fill1_err", 32'(err), 32'd0);
    host_req = 1'b0;
    $display("initial fill complete");

    host_op("hrd0", 1'b0, 8'd0, '0, 32'd0);
    host_op("hrd5", 1'b0, 8'd5, '0, 32'd0);
    host_op("hrd255", 1'b0, 8'd255, '0, 32'd0);

    // ---------------- Core write then read-after-write ----------------
    cenb = 1'b0; wenb = 1'b0; addr = 8'd3; data = 32'hDEADBEEF;
    tick();
    ref_mem[3] = 32'hDEADBEEF;
    cenb = 1'b0; wenb = 1'b1; addr = 8'd3;
    #1;
    check("cwr_data_o_unchanged", data_out, 32'd0);
    tick();
    cenb = 1'b1;
    check("crd3_data_o", data_out, 32'hDEADBEEF);
    tick();
    check("crd3_hold", data_out, 32'hDEADBEEF);
    $display("core WR addr=3 0xdeadbeef then RD data_o=0x%08h", data_out);

    // ---------------- Host stalled by four core reads ----------------
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    cenb = 1'b0; wenb = 1'b1; addr = 8'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_gnt", 32'(host_gnt), 32'd0);
      tick();
    end
    cenb = 1'b1;
    host_op("hrd3_after_stall", 1'b0, 8'd3, '0, 32'hDEADBEEF);
    check("stall_core_data_o", data_out, 32'd0);

    // ---------------- Randomized mixed traffic ----------------
    exp_data_o = ref_mem[5];
    exp_rdata  = 32'hDEADBEEF;
    for (int i = 0; i < 300; i++) begin
      cenb       = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      wenb       = 1'($urandom_range(0, 1));
      addr       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      data       = $urandom;
      host_req   = 1'($urandom_range(0, 1));
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      host_wdata = $urandom;
      #1;
      check("rnd_gnt", 32'(host_gnt), 32'(host_req & cenb));
      exp_rvalid = 1'b0;
      if (!cenb) begin
        if (!wenb) ref_mem[addr] = data;
        else exp_data_o = ref_mem[addr];
      end else if (host_req) begin
        if (host_we) begin
          ref_mem[host_addr] = host_wdata;
        end else begin
          exp_rvalid = 1'b1;
          exp_rdata  = ref_mem[host_addr];
        end
      end
      tick();
      check("rnd_data_o", data_out, exp_data_o);
      check("rnd_rvalid", 32'(host_rvalid), 32'(exp_rvalid));
      check("rnd_rdata", host_rdata, exp_rdata);
      $display("rnd %0d core cenb=%0b wenb=%0b addr=%0d host req=%0b we=%0b addr=%0d data_o=0x%08h rdata=0x%08h",
               i, cenb, wenb, addr, host_req, host_we, host_addr, data_out, host_rdata);
    end
    cenb = 1'b1;
    host_req = 1'b0;
    check("rnd_err", 32'(err), 32'd0);

    // ---------------- Host write, clear, core access during INIT ---------
    host_op("hwr7", 1'b1, 8'd7, 32'h0000_1234, '0);
    host_op("hrd7", 1'b0, 8'd7, '0, 32'h0000_1234);
    cenb = 1'b0; wenb = 1'b1; addr = 8'd7;
    tick();
    cenb = 1'b1;
    check("crd7_data_o", data_out, 32'h0000_1234);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    check("clear_err", 32'(err), 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == 10) begin
        cenb = 1'b0; wenb = 1'b1; addr = 8'd7;
      end
      tick();
      cenb = 1'b1;
      if (i == 10) begin
        check("init_rd_data_o", data_out, 32'd0);
        check("init_rd_err", 32'(err), 32'd1);
        $display("core RD during fill: data_o=0x%08h err=%0b", data_out, err);
      end
      check("fill2_busy", 32'(busy), (i < DEPTH) ? 32'd1 : 32'd0);
    end
    check("err_sticky", 32'(err), 32'd1);
    host_op("hrd7_cleared", 1'b0, 8'd7, '0, 32'd0);
    host_op("hrd3_cleared", 1'b0, 8'd3, '0, 32'd0);

    // ---------------- Reset in the middle of a fill ----------------
    host_op("hwr200", 1'b1, 8'd200, 32'hA5A5_A5A5, '0);
    host_op("hrd200", 1'b0, 8'd200, '0, 32'hA5A5_A5A5);
    cenb = 1'b0; wenb = 1'b1; addr = 8'd200;
    tick();
    cenb = 1'b1;
    check("crd200_data_o", data_out, 32'hA5A5_A5A5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    rstn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_data_o", data_out, 32'd0);
    check("midrst_rdata", host_rdata, 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    tick();
    rstn = 1'b1;
    $display("reset pulsed mid-fill");
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      check("fill3_busy", 32'(busy), (i < DEPTH) ? 32'd1 : 32'd0);
    end
    host_op("hrd200_refill", 1'b0, 8'd200, '0, ref_mem[200]);
    host_op("hrd7_refill", 1'b0, 8'd7, '0, ref_mem[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
